// File: rtl/tl_uh_mem_responder_pkg.sv
// Shared TileLink UH opcodes, responder FSM states and burst helpers.
package tl_pkg;

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_ARITH       = 3'd2;
  localparam logic [2:0] A_LOGICAL     = 3'd3;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] A_INTENT      = 3'd5;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;

  // Wide enough for the largest encodable a_size (2^13 beats).
  localparam int BEAT_W = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_ACK
  } state_e;

  function automatic logic [BEAT_W-1:0] beats_from_size(input logic [3:0] size);
    if (size <= 4'd2) return BEAT_W'(1);
    return BEAT_W'(1) << (size - 4'd2);
  endfunction

endpackage

// File: rtl/tl_uh_mem_responder_sram.sv
// Single-port synchronous SRAM, 32-bit words, byte-masked write, 1-cycle read.
module tl_sram #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [(1 << AW)];
  logic [31:0] rdata_q;

  // rdata_q holds between reads; the responder uses it as its D data slot.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/tl_uh_mem_responder.sv
// TL-UH slave over local SRAM: Get/Put bursts, hints, denial of unservable requests.
module tl_uh_mem_responder
  import tl_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int          MEM_WORDS_LOG2 = 14,
  parameter int          MAX_SIZE       = 7
) (
  input  logic        core_clock_i,
  input  logic        core_resetn_i,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [3:0]  a_size,
  input  logic [31:0] a_address,
  input  logic [3:0]  a_mask,
  input  logic [31:0] a_data,
  input  logic        a_corrupt,
  input  logic        a_valid,
  output logic        a_ready,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [3:0]  d_size,
  output logic        d_denied,
  output logic [31:0] d_data,
  output logic        d_corrupt,
  output logic        d_valid,
  input  logic        d_ready
);

  localparam int          AW         = MEM_WORDS_LOG2;
  localparam logic [32:0] WIN_LO     = {1'b0, ADDR_BASE};
  localparam logic [32:0] WIN_HI     = WIN_LO + (33'd4 << AW);
  localparam logic [3:0]  MAX_SIZE_L = 4'(MAX_SIZE);

  state_e              state_q, state_d;
  logic                run_q;
  logic [3:0]          size_q, size_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [BEAT_W-1:0]   left_q, left_d;
  logic                denied_q, denied_d;
  logic                hint_q, hint_d;
  logic                atomic_q, atomic_d;
  logic                dvld_q, dvld_d;

  logic                mem_we, mem_re;
  logic [AW-1:0]       mem_addr;
  logic [31:0]         mem_rdata;

  logic [AW-1:0]       a_idx;
  logic [31:0]         align_mask;
  logic [BEAT_W-1:0]   req_beats;
  logic                req_denied, is_atomic, a_fire;
  logic                unused_a_param;

  assign unused_a_param = ^a_param;
  assign a_idx          = a_address[AW+1:2];
  assign a_ready        = run_q && (state_q == ST_IDLE || state_q == ST_WRITE);
  assign a_fire         = a_valid && a_ready;

  always_comb begin
    align_mask = (32'd1 << a_size) - 32'd1;
    req_beats  = beats_from_size(a_size);
    is_atomic  = (a_opcode == A_ARITH) || (a_opcode == A_LOGICAL);
    req_denied = ({1'b0, a_address} < WIN_LO) || ({1'b0, a_address} >= WIN_HI) ||
                 ((a_address & align_mask) != 32'd0) || (a_size > MAX_SIZE_L) ||
                 is_atomic || (a_opcode > A_INTENT);
  end

  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    idx_d    = idx_q;
    left_d   = left_q;
    denied_d = denied_q;
    hint_d   = hint_q;
    atomic_d = atomic_q;
    dvld_d   = dvld_q;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (a_fire) begin
          size_d   = a_size;
          idx_d    = a_idx;
          left_d   = req_beats;
          denied_d = req_denied;
          hint_d   = (a_opcode == A_INTENT);
          atomic_d = is_atomic;
          case (a_opcode)
            A_GET: state_d = ST_READ;
            A_PUT_FULL, A_PUT_PARTIAL, A_ARITH, A_LOGICAL: begin
              // The first handshake already carries beat 0's data.
              mem_we   = !req_denied && !a_corrupt;
              mem_addr = a_idx;
              idx_d    = a_idx + AW'(1);
              left_d   = req_beats - BEAT_W'(1);
              if (req_beats != BEAT_W'(1)) begin
                state_d = ST_WRITE;
              end else if (is_atomic) begin
                state_d = ST_READ;
                left_d  = req_beats;
              end else begin
                state_d = ST_ACK;
              end
            end
            default: state_d = ST_ACK;
          endcase
        end
      end
      ST_WRITE: begin
        if (a_fire) begin
          mem_we = !denied_q && !a_corrupt;
          idx_d  = idx_q + AW'(1);
          left_d = left_q - BEAT_W'(1);
          if (left_q == BEAT_W'(1)) begin
            if (atomic_q) begin
              state_d = ST_READ;
              left_d  = beats_from_size(size_q);
            end else begin
              state_d = ST_ACK;
            end
          end
        end
      end
      ST_READ: begin
        // Fetch only into an empty or draining slot so stalls never drop a beat.
        if (left_q != '0 && (!dvld_q || d_ready)) begin
          mem_re = !denied_q;
          idx_d  = idx_q + AW'(1);
          left_d = left_q - BEAT_W'(1);
          dvld_d = 1'b1;
        end else if (dvld_q && d_ready) begin
          dvld_d = 1'b0;
          if (left_q == '0) state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (d_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge core_clock_i or negedge core_resetn_i) begin
    if (!core_resetn_i) begin
      state_q  <= ST_IDLE;
      run_q    <= 1'b0;
      size_q   <= '0;
      idx_q    <= '0;
      left_q   <= '0;
      denied_q <= 1'b0;
      hint_q   <= 1'b0;
      atomic_q <= 1'b0;
      dvld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= 1'b1;
      size_q   <= size_d;
      idx_q    <= idx_d;
      left_q   <= left_d;
      denied_q <= denied_d;
      hint_q   <= hint_d;
      atomic_q <= atomic_d;
      dvld_q   <= dvld_d;
    end
  end

  always_comb begin
    d_valid   = 1'b0;
    d_opcode  = D_ACCESS_ACK;
    d_denied  = 1'b0;
    d_corrupt = 1'b0;
    d_data    = '0;
    d_param   = '0;
    d_size    = size_q;
    if (state_q == ST_READ) begin
      d_valid   = dvld_q;
      d_opcode  = D_ACCESS_ACK_DATA;
      d_denied  = denied_q;
      d_corrupt = denied_q;
      d_data    = (dvld_q && !denied_q) ? mem_rdata : 32'd0;
    end else if (state_q == ST_ACK) begin
      d_valid  = 1'b1;
      d_opcode = hint_q ? D_HINT_ACK : D_ACCESS_ACK;
      d_denied = denied_q;
    end
  end

  tl_sram #(.AW(AW)) u_sram (
    .clk   (core_clock_i),
    .we    (mem_we),
    .be    (a_mask),
    .addr  (mem_addr),
    .wdata (a_data),
    .re    (mem_re),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_tl_uh_mem_responder.sv
// Directed bench for tl_uh_mem_responder with a transaction-level memory/response model.
module tb_tl_uh_mem_responder;

  logic        clk;
  logic        rstn;
  logic [2:0]  a_opcode, a_param;
  logic [3:0]  a_size, a_mask;
  logic [31:0] a_address, a_data;
  logic        a_corrupt, a_valid, a_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic        d_denied, d_corrupt, d_valid, d_ready;
  logic [31:0] d_data;

  tl_uh_mem_responder dut (
    .core_clock_i (clk),       .core_resetn_i (rstn),
    .a_opcode     (a_opcode),  .a_param       (a_param),
    .a_size       (a_size),    .a_address     (a_address),
    .a_mask       (a_mask),    .a_data        (a_data),
    .a_corrupt    (a_corrupt), .a_valid       (a_valid),
    .a_ready      (a_ready),
    .d_opcode     (d_opcode),  .d_param       (d_param),
    .d_size       (d_size),    .d_denied      (d_denied),
    .d_data       (d_data),    .d_corrupt     (d_corrupt),
    .d_valid      (d_valid),   .d_ready       (d_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic        den;
    logic        cor;
    logic [3:0]  size;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] mm [int];
  int          vectors = 0;
  int          miscompares = 0;
  int          beats_seen = 0;
  logic [31:0] last_data = '0;
  rsp_t        last_rsp = '0;
  bit          rdy_toggle = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_denied(input logic [2:0] op, input logic [3:0] size,
                                      input logic [31:0] addr);
    longint a = longint'(addr);
    if (a < 0 || a >= 4 * (longint'(1) << 14)) return 1;
    if (a % (longint'(1) << size) != 0) return 1;
    if (size > 7) return 1;
    if (op == 2 || op == 3 || op > 5) return 1;
    return 0;
  endfunction

  // d_ready driver: constant high or toggling every cycle.
  initial begin
    d_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 d_ready = rdy_toggle ? ~d_ready : 1'b1;
    end
  end

  // Compare process: every D handshake against the model queue, plus hold during stalls.
  rsp_t cur, prev;
  bit   stall_prev = 0;
  always @(negedge clk) begin
    if (!rstn) begin
      stall_prev = 0;
    end else begin
      cur = {d_opcode, d_denied, d_corrupt, d_size, d_data};
      if (stall_prev) check("d_hold", {d_valid, cur}, {1'b1, prev});
      if (d_valid && d_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL d_extra: got beat %h, expected none", cur);
        end else begin
          check("d_beat", cur, exp_q.pop_front());
          check("d_param", d_param, 0);
          last_data = d_data;
          last_rsp  = cur;
          beats_seen++;
        end
      end
      stall_prev = d_valid && !d_ready;
      prev       = cur;
    end
  end

  task automatic a_req(input logic [2:0] op, input logic [3:0] size, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] data, input logic [31:0] step,
                       input logic corrupt, input int gap_at);
    int beats = (size <= 2) ? 1 : (1 << (size - 2));
    int a_beats = (op <= 3) ? beats : 1;
    bit den = model_denied(op, size, addr);
    int widx = (addr >> 2) & 32'h3fff;
    int n;
    for (int i = 0; i < a_beats; i++) begin
      if (i == gap_at) @(negedge clk);
      @(negedge clk);
      a_opcode = op; a_size = size; a_address = addr; a_mask = mask;
      a_data = data + step * i; a_corrupt = corrupt; a_param = 3'd5; a_valid = 1'b1;
      n = 0;
      while (!a_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!a_ready) begin
        vectors++;
        miscompares++;
        $display("FAIL a_ready_wait: got a_ready 0 after 200 cycles, expected 1");
        a_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1 a_valid = 1'b0;
      if (op <= 1 && !den && !corrupt) begin
        int k = (widx + i) & 32'h3fff;
        logic [31:0] w = mm.exists(k) ? mm[k] : 32'h0;
        for (int b = 0; b < 4; b++) if (mask[b]) w[8*b +: 8] = a_data[8*b +: 8];
        mm[k] = w;
      end
    end
    if (op == 4 || op == 2 || op == 3) begin
      for (int i = 0; i < beats; i++) begin
        int k = (widx + i) & 32'h3fff;
        logic [31:0] w = (den || !mm.exists(k)) ? 32'h0 : mm[k];
        exp_q.push_back({3'd1, den, den, size, w});
      end
    end else if (op <= 1) begin
      exp_q.push_back({3'd0, den, 1'b0, size, 32'h0});
    end else if (op == 5) begin
      exp_q.push_back({3'd2, den, 1'b0, size, 32'h0});
    end else begin
      exp_q.push_back({3'd0, 1'b1, 1'b0, size, 32'h0});
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int n, b0;
    rstn = 1'b0;
    a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0;
    a_address = '0; a_mask = '0; a_data = '0; a_corrupt = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a_ready", a_ready, 0);
    check("rst_d_valid", d_valid, 0);
    check("rst_d_fields", {d_opcode, d_data, d_denied, d_corrupt, d_size}, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_rel_ready", a_ready, 1);

    // PutFull then Get, with exact latencies.
    a_req(3'd0, 4'd2, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0, -1);
    @(negedge clk);
    check("put_ack_lat", {d_valid, d_opcode, d_denied}, {1'b1, 3'd0, 1'b0});
    wait_drain();
    a_req(3'd4, 4'd2, 32'h100, 4'hF, 0, 0, 0, -1);
    @(negedge clk);
    check("get_lat_n1", d_valid, 0);
    @(negedge clk);
    check("get_lat_n2", {d_valid, d_data}, {1'b1, 32'hDEADBEEF});
    wait_drain();

    // PutPartial merges low half.
    a_req(3'd1, 4'd2, 32'h100, 4'h3, 32'h0000_1234, 0, 0, -1);
    wait_drain();
    a_req(3'd4, 4'd2, 32'h100, 4'hF, 0, 0, 0, -1);
    wait_drain();
    check("partial_pin", last_data, 32'hDEAD1234);

    // 32-beat burst write with a gap, read back under back-pressure.
    a_req(3'd0, 4'd7, 32'h80, 4'hF, 0, 1, 0, 5);
    wait_drain();
    rdy_toggle = 1;
    b0 = beats_seen;
    a_req(3'd4, 4'd7, 32'h80, 4'hF, 0, 0, 0, -1);
    wait_drain();
    rdy_toggle = 0;
    check("burst_beats", beats_seen - b0, 32);
    check("burst_last", {last_rsp.size, last_data}, {4'd7, 32'd31});

    // Throughput with d_ready high: 32 consecutive valid cycles.
    a_req(3'd4, 4'd7, 32'h80, 4'hF, 0, 0, 0, -1);
    @(negedge clk);
    @(negedge clk);
    n = 0;
    while (d_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("get_thru", n, 32);
    wait_drain();

    // Denials: misaligned, out of window, oversize.
    b0 = beats_seen;
    a_req(3'd4, 4'd3, 32'h104, 4'hF, 0, 0, 0, -1);
    wait_drain();
    check("misalign_pin", {beats_seen - b0, last_rsp.den, last_rsp.cor, last_data}, {32'd2, 2'b11, 32'd0});
    a_req(3'd4, 4'd2, 32'h0004_0000, 4'hF, 0, 0, 0, -1);
    wait_drain();
    check("oob_pin", {last_rsp.op, last_rsp.den}, {3'd1, 1'b1});
    a_req(3'd4, 4'd8, 32'h0, 4'hF, 0, 0, 0, -1);
    wait_drain();

    // Intent, Arithmetic, unknown opcode.
    a_req(3'd5, 4'd2, 32'h200, 4'hF, 0, 0, 0, -1);
    wait_drain();
    check("intent_pin", {last_rsp.op, last_rsp.den}, {3'd2, 1'b0});
    a_req(3'd2, 4'd2, 32'h100, 4'hF, 32'h5555_5555, 0, 0, -1);
    wait_drain();
    check("arith_pin", {last_rsp.op, last_rsp.den, last_rsp.cor}, {3'd1, 2'b11});
    a_req(3'd4, 4'd2, 32'h100, 4'hF, 0, 0, 0, -1);
    wait_drain();
    check("arith_mem", last_data, 32'hDEAD1234);
    a_req(3'd7, 4'd2, 32'h100, 4'hF, 0, 0, 0, -1);
    wait_drain();
    check("bad_op_pin", {last_rsp.op, last_rsp.den}, {3'd0, 1'b1});

    // Reset in the middle of a read burst.
    b0 = beats_seen;
    a_req(3'd4, 4'd7, 32'h80, 4'hF, 0, 0, 0, -1);
    n = 0;
    while (beats_seen < b0 + 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach", beats_seen - b0, 10);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid", {d_valid, a_ready, d_data, d_size}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", a_ready, 1);
    a_req(3'd4, 4'd7, 32'h80, 4'hF, 0, 0, 0, -1);
    wait_drain();
    check("rst_after_pin", last_data, 32'd31);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
